// File: rtl/fdc_pkg.sv
// ============================================================================
//  Module      : fdc_pkg
//  Description : Shared constants for the floppy sector DMA engine.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package fdc_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RD_SRC = 2'd1;
    localparam logic [1:0] ST_WR_DST = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [1:0] RW_READ  = 2'b10;
    localparam logic [1:0] RW_WRITE = 2'b01;

    localparam int CYLS    = 80;
    localparam int HEADS   = 2;
    localparam int SPT     = 18;
    localparam int MAX_LBA = CYLS * HEADS * SPT - 1;

endpackage

`default_nettype wire

// File: rtl/fdc_sector_dma.sv
// ============================================================================
//  Module      : fdc_sector_dma
//  Description : Copies one 512-byte sector between disk-image store and guest memory.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module fdc_sector_dma #(
    parameter logic [23:0] IMG_BASE  = 24'h100000,
    parameter int          SEC_WORDS = 256,
    parameter int          MAX_LBA   = fdc_pkg::MAX_LBA
) (
    input  logic        iClk,
    input  logic        iRst,
    input  logic [1:0]  iReqRW,
    input  logic [11:0] iLBA,
    input  logic [19:0] iDmaAdr,
    output logic        oAckRW,
    output logic        oErr,
    output logic        oBusy,
    output logic [23:0] oImgAdr,
    output logic [1:0]  oImgRW,
    output logic [15:0] oImgData,
    input  logic [15:0] iImgData,
    input  logic        iImgAck,
    output logic [18:0] oMemAdr,
    output logic [1:0]  oMemRW,
    output logic [15:0] oMemData,
    input  logic [15:0] iMemData,
    input  logic        iMemAck
);

    import fdc_pkg::*;

    localparam logic [8:0]  c_LAST_WCNT = 9'(SEC_WORDS - 1);
    localparam logic [11:0] c_MAX_LBA   = 12'(MAX_LBA);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic        r_dir_rd;
    logic [11:0] r_lba;
    logic [18:0] r_word_adr;
    logic [8:0]  r_wcnt;
    logic [15:0] r_hold;
    logic        r_err;

    logic        w_req_any;
    logic        w_req_bad;
    logic        w_src_ack;
    logic        w_dst_ack;
    logic [15:0] w_src_data;
    logic [23:0] w_img_adr;
    logic [18:0] w_mem_adr;
    logic        w_unused_adr0;

    assign w_req_any     = (iReqRW != 2'b00);
    assign w_req_bad     = (iReqRW == 2'b11) || (iLBA > c_MAX_LBA);
    assign w_unused_adr0 = iDmaAdr[0];

    // Direction picks which bus is source and which is destination.
    assign w_src_ack  = r_dir_rd ? iImgAck  : iMemAck;
    assign w_dst_ack  = r_dir_rd ? iMemAck  : iImgAck;
    assign w_src_data = r_dir_rd ? iImgData : iMemData;

    assign w_img_adr = IMG_BASE + {4'h0, r_lba, 8'h00} + {15'h0, r_wcnt};
    assign w_mem_adr = r_word_adr + {10'h0, r_wcnt};

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req_any) w_state_nxt = w_req_bad ? ST_DONE : ST_RD_SRC;
            ST_RD_SRC: if (w_src_ack) w_state_nxt = ST_WR_DST;
            ST_WR_DST: if (w_dst_ack) w_state_nxt = (r_wcnt == c_LAST_WCNT) ? ST_DONE : ST_RD_SRC;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            r_dir_rd   <= 1'b0;
            r_lba      <= 12'h0;
            r_word_adr <= 19'h0;
            r_wcnt     <= 9'h0;
            r_hold     <= 16'h0;
            r_err      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req_any) begin
                        r_err <= w_req_bad;
                        if (!w_req_bad) begin
                            r_dir_rd   <= iReqRW[1];
                            r_lba      <= iLBA;
                            r_word_adr <= iDmaAdr[19:1];
                            r_wcnt     <= 9'h0;
                        end
                    end
                end
                ST_RD_SRC: if (w_src_ack) r_hold <= w_src_data;
                ST_WR_DST: if (w_dst_ack) r_wcnt <= r_wcnt + 9'd1;
                default: ;
            endcase
        end
    end

    // Bus outputs are decoded from state so a reset drops them immediately.
    always_comb begin
        oAckRW   = (r_state == ST_DONE);
        oBusy    = (r_state != ST_IDLE);
        oErr     = r_err;
        oImgRW   = 2'b00;
        oImgAdr  = 24'h0;
        oImgData = 16'h0;
        oMemRW   = 2'b00;
        oMemAdr  = 19'h0;
        oMemData = 16'h0;
        case (r_state)
            ST_RD_SRC: begin
                if (r_dir_rd) begin
                    oImgRW  = RW_READ;
                    oImgAdr = w_img_adr;
                end else begin
                    oMemRW  = RW_READ;
                    oMemAdr = w_mem_adr;
                end
            end
            ST_WR_DST: begin
                if (r_dir_rd) begin
                    oMemRW   = RW_WRITE;
                    oMemAdr  = w_mem_adr;
                    oMemData = r_hold;
                end else begin
                    oImgRW   = RW_WRITE;
                    oImgAdr  = w_img_adr;
                    oImgData = r_hold;
                end
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fdc_sector_dma.sv
// ============================================================================
//  Module      : tb_fdc_sector_dma
//  Description : Directed self-checking bench for fdc_sector_dma.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_fdc_sector_dma;

    logic        clk;
    logic        rst_n;
    logic [1:0]  iReqRW;
    logic [11:0] iLBA;
    logic [19:0] iDmaAdr;
    logic        oAckRW, oErr, oBusy;
    logic [23:0] oImgAdr;
    logic [1:0]  oImgRW;
    logic [15:0] oImgData;
    logic [15:0] img_rdata;
    logic        img_ack;
    logic [18:0] oMemAdr;
    logic [1:0]  oMemRW;
    logic [15:0] oMemData;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    fdc_sector_dma dut (
        .iClk(clk), .iRst(rst_n), .iReqRW(iReqRW), .iLBA(iLBA), .iDmaAdr(iDmaAdr),
        .oAckRW(oAckRW), .oErr(oErr), .oBusy(oBusy),
        .oImgAdr(oImgAdr), .oImgRW(oImgRW), .oImgData(oImgData),
        .iImgData(img_rdata), .iImgAck(img_ack),
        .oMemAdr(oMemAdr), .oMemRW(oMemRW), .oMemData(oMemData),
        .iMemData(mem_rdata), .iMemAck(mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int max_dly = 0;
    int cyc = 0;
    int rw_act = 0;
    int ack_cnt = 0;

    logic [23:0] img_rd_adr[$];
    logic [23:0] img_wr_adr[$];
    logic [15:0] img_wr_dat[$];
    logic [18:0] mem_rd_adr[$];
    logic [18:0] mem_wr_adr[$];
    logic [15:0] mem_wr_dat[$];

    int req_cyc, lat;
    logic err_at_ack, busy_at_ack, busy_after, ack_after;

    function automatic logic [15:0] img_pat(input logic [23:0] a);
        return a[15:0] ^ {a[23:16], 8'h5A};
    endfunction

    function automatic logic [15:0] mem_pat(input logic [18:0] a);
        return ~a[15:0] ^ {13'h0, a[18:16]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (oImgRW != 2'b00 || oMemRW != 2'b00) rw_act <= rw_act + 1;
        if (oAckRW) ack_cnt <= ack_cnt + 1;
    end

    // Bus responders: ack appears dly cycles after the minimum two-cycle handshake.
    initial begin
        int cnt, dly;
        cnt = 0; dly = 0; img_ack = 1'b0; img_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                img_ack = 1'b0; cnt = 0;
            end else if (img_ack) begin
                img_ack = 1'b0;
            end else if (oImgRW != 2'b00) begin
                if (cnt == 0) dly = int'($urandom_range(0, max_dly));
                cnt++;
                if (cnt >= dly + 2) begin
                    cnt = 0; img_ack = 1'b1;
                    if (oImgRW == 2'b10) begin
                        img_rd_adr.push_back(oImgAdr);
                        img_rdata = img_pat(oImgAdr);
                    end else begin
                        img_wr_adr.push_back(oImgAdr);
                        img_wr_dat.push_back(oImgData);
                    end
                end
            end
        end
    end

    initial begin
        int cnt, dly;
        cnt = 0; dly = 0; mem_ack = 1'b0; mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mem_ack = 1'b0; cnt = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0;
            end else if (oMemRW != 2'b00) begin
                if (cnt == 0) dly = int'($urandom_range(0, max_dly));
                cnt++;
                if (cnt >= dly + 2) begin
                    cnt = 0; mem_ack = 1'b1;
                    if (oMemRW == 2'b10) begin
                        mem_rd_adr.push_back(oMemAdr);
                        mem_rdata = mem_pat(oMemAdr);
                    end else begin
                        mem_wr_adr.push_back(oMemAdr);
                        mem_wr_dat.push_back(oMemData);
                    end
                end
            end
        end
    end

    task automatic start_req(input logic [1:0] rw, input logic [11:0] lba, input logic [19:0] dma);
        @(negedge clk);
        img_rd_adr = {}; img_wr_adr = {}; img_wr_dat = {};
        mem_rd_adr = {}; mem_wr_adr = {}; mem_wr_dat = {};
        iReqRW = rw; iLBA = lba; iDmaAdr = dma;
        req_cyc = cyc;
        @(negedge clk);
        iReqRW = 2'b00;
    endtask

    task automatic wait_ack(input string tag);
        int n;
        n = 0;
        while (!oAckRW && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (!oAckRW) chk({tag, " ack timeout"}, 32'd0, 32'd1);
        lat = cyc - req_cyc + 1;
        err_at_ack = oErr;
        busy_at_ack = oBusy;
        @(negedge clk);
        busy_after = oBusy;
        ack_after = oAckRW;
    endtask

    task automatic verify_sector(input string tag, input bit is_rd, input int lba, input logic [19:0] dma);
        logic [23:0] ibase;
        logic [18:0] mbase;
        int n_src, n_dst;
        ibase = 24'(32'h100000 + lba * 256);
        mbase = dma[19:1];
        n_src = is_rd ? img_rd_adr.size() : mem_rd_adr.size();
        n_dst = is_rd ? mem_wr_adr.size() : img_wr_adr.size();
        chk({tag, " src count"}, n_src, 256);
        chk({tag, " dst count"}, n_dst, 256);
        if (n_src == 256 && n_dst == 256) begin
            for (int i = 0; i < 256; i++) begin
                logic [23:0] ia;
                logic [18:0] ma;
                ia = ibase + 24'(i);
                ma = mbase + 19'(i);
                if (is_rd) begin
                    chk($sformatf("%s img rd adr %0d", tag, i), img_rd_adr[i], ia);
                    chk($sformatf("%s mem wr adr %0d", tag, i), mem_wr_adr[i], ma);
                    chk($sformatf("%s mem wr data %0d", tag, i), mem_wr_dat[i], img_pat(ia));
                end else begin
                    chk($sformatf("%s mem rd adr %0d", tag, i), mem_rd_adr[i], ma);
                    chk($sformatf("%s img wr adr %0d", tag, i), img_wr_adr[i], ia);
                    chk($sformatf("%s img wr data %0d", tag, i), img_wr_dat[i], mem_pat(ma));
                end
            end
        end
    endtask

    initial begin
        int snap_rw, snap_ack, n;
        rst_n = 1'b0; iReqRW = 2'b00; iLBA = 12'h0; iDmaAdr = 20'h0;
        #3;
        chk("rst ack", oAckRW, 0);
        chk("rst err", oErr, 0);
        chk("rst busy", oBusy, 0);
        chk("rst imgrw", oImgRW, 0);
        chk("rst memrw", oMemRW, 0);
        chk("rst imgadr", oImgAdr, 0);
        chk("rst memadr", oMemAdr, 0);
        chk("rst imgdata", oImgData, 0);
        chk("rst memdata", oMemData, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Read, zero-wait: 1 accept + 256*4 + 1 done cycles
        start_req(2'b10, 12'd0, 20'h08000);
        wait_ack("t1");
        chk("t1 latency", lat, 1026);
        chk("t1 err", err_at_ack, 0);
        chk("t1 busy at ack", busy_at_ack, 1);
        chk("t1 busy after", busy_after, 0);
        chk("t1 ack after", ack_after, 0);
        verify_sector("t1", 1'b1, 0, 20'h08000);

        // Out-of-range LBA and illegal direction
        snap_rw = rw_act;
        start_req(2'b10, 12'd2880, 20'h0);
        wait_ack("t3a");
        chk("t3a latency", lat, 2);
        chk("t3a err", err_at_ack, 1);
        chk("t3a bus quiet", rw_act - snap_rw, 0);
        snap_rw = rw_act;
        start_req(2'b11, 12'd0, 20'h0);
        wait_ack("t3b");
        chk("t3b latency", lat, 2);
        chk("t3b err", err_at_ack, 1);
        chk("t3b err held", oErr, 1);
        chk("t3b bus quiet", rw_act - snap_rw, 0);

        // Write at the last LBA
        start_req(2'b01, 12'd2879, 20'h10000);
        wait_ack("t2");
        chk("t2 err", err_at_ack, 0);
        if (img_wr_adr.size() > 0) chk("t2 first img adr", img_wr_adr[0], 24'h1B3F00);
        else chk("t2 first img adr", 32'hFFFFFFFF, 24'h1B3F00);
        if (mem_rd_adr.size() > 0) chk("t2 first mem adr", mem_rd_adr[0], 19'h08000);
        else chk("t2 first mem adr", 32'hFFFFFFFF, 19'h08000);
        verify_sector("t2", 1'b0, 2879, 20'h10000);

        // Random wait states with a stray request while busy
        max_dly = 7;
        start_req(2'b10, 12'd1234, 20'h2468B);
        repeat (60) @(negedge clk);
        iReqRW = 2'b01; iLBA = 12'd7; iDmaAdr = 20'h00000;
        @(negedge clk);
        iReqRW = 2'b00;
        wait_ack("t4");
        chk("t4 err", err_at_ack, 0);
        verify_sector("t4", 1'b1, 1234, 20'h2468B);
        snap_rw = rw_act;
        repeat (10) @(negedge clk);
        chk("t4 no second xfer", rw_act - snap_rw, 0);
        chk("t4 no img writes", img_wr_adr.size(), 0);
        chk("t4 idle busy", oBusy, 0);
        max_dly = 0;

        // Reset in the middle of a sector
        start_req(2'b10, 12'd3, 20'h02000);
        n = 0;
        while (mem_wr_adr.size() < 100 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("t5 reached word 100", mem_wr_adr.size() >= 100, 1);
        #2;
        chk("t5 bus active before rst", (oImgRW != 2'b00) || (oMemRW != 2'b00), 1);
        snap_ack = ack_cnt;
        rst_n = 1'b0;
        #1;
        chk("t5 imgrw async", oImgRW, 0);
        chk("t5 memrw async", oMemRW, 0);
        chk("t5 busy async", oBusy, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        chk("t5 no ack", ack_cnt - snap_ack, 0);
        chk("t5 idle", oBusy, 0);
        start_req(2'b10, 12'd9, 20'h00100);
        wait_ack("t5b");
        if (img_rd_adr.size() > 0) chk("t5b restart adr", img_rd_adr[0], 24'h100900);
        else chk("t5b restart adr", 32'hFFFFFFFF, 24'h100900);
        verify_sector("t5b", 1'b1, 9, 20'h00100);

        // Guest address wraps at 1 MB
        start_req(2'b10, 12'd1, 20'hFFF00);
        wait_ack("t6");
        chk("t6 err", err_at_ack, 0);
        if (mem_wr_adr.size() == 256) begin
            chk("t6 word 127 adr", mem_wr_adr[127], 19'h7FFFF);
            chk("t6 word 128 adr", mem_wr_adr[128], 19'h00000);
        end
        verify_sector("t6", 1'b1, 1, 20'hFFF00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
